// File: rtl/round_robin_fifo_dispatcher.sv
// Single-producer, four-consumer dispatcher: one FIFO feeding channels a..d
// in round-robin order, serving only consumers that assert ready.
module round_robin_fifo_dispatcher #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wen,
  input  logic [WIDTH-1:0] din,
  input  logic [3:0]       ready,
  output logic [WIDTH-1:0] dout,
  output logic [3:0]       valid,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [1:0]       rr_ptr;

  logic [7:0] ready_dbl;
  logic [3:0] ready_rot;
  logic [1:0] offset;
  logic [1:0] sel;
  logic       push;
  logic       pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Rotate ready so bit 0 is the channel at rr_ptr, then take the first set bit.
  assign ready_dbl = {ready, ready} >> rr_ptr;
  assign ready_rot = ready_dbl[3:0];

  always_comb begin
    offset = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (ready_rot[k]) offset = 2'(k);
    end
  end

  assign sel  = 2'(rr_ptr + offset);
  assign push = wen && !full;
  assign pop  = !empty && (ready != 4'b0000);

  // Storage has no reset; resetting the pointers discards its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rr_ptr   <= 2'd0;
      count    <= '0;
      dout     <= '0;
      valid    <= 4'b0000;
      overflow <= 1'b0;
    end else begin
      overflow <= wen && full;
      if (push) wr_ptr <= PW'(wr_ptr + PW'(1));
      if (pop) begin
        dout   <= mem[rd_ptr];
        valid  <= 4'b0001 << sel;
        rd_ptr <= PW'(rd_ptr + PW'(1));
        rr_ptr <= 2'(sel + 2'd1);
      end else begin
        dout  <= '0;
        valid <= 4'b0000;
      end
      case ({push, pop})
        2'b10:   count <= CW'(count + CW'(1));
        2'b01:   count <= CW'(count - CW'(1));
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_round_robin_fifo_dispatcher.sv
// Directed, table-driven bench for round_robin_fifo_dispatcher.
module tb_round_robin_fifo_dispatcher;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wen;
  logic [7:0] din;
  logic [3:0] ready;
  logic [7:0] dout;
  logic [3:0] valid;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       wen;
    logic [7:0] din;
    logic [3:0] ready;
    logic [3:0] valid;
    logic [7:0] dout;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
  } vec_t;

  vec_t vecs[$];

  round_robin_fifo_dispatcher #(.WIDTH(8), .DEPTH(8), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .din(din), .ready(ready),
    .dout(dout), .valid(valid), .full(full), .empty(empty),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic w, input logic [7:0] d, input logic [3:0] r,
                              input logic [3:0] v, input logic [7:0] o, input logic [3:0] c,
                              input logic f, input logic e, input logic ov);
    vec_t t;
    t.wen = w; t.din = d; t.ready = r; t.valid = v; t.dout = o;
    t.count = c; t.full = f; t.empty = e; t.overflow = ov;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input logic [3:0] v, input logic [7:0] o,
                         input logic [3:0] c, input logic ov);
    chk({tag, "_valid"}, idx, 32'(valid), 32'(v));
    chk({tag, "_dout"}, idx, 32'(dout), 32'(o));
    chk({tag, "_count"}, idx, 32'(count), 32'(c));
    chk({tag, "_full"}, idx, 32'(full), 32'(c == 4'd8));
    chk({tag, "_empty"}, idx, 32'(empty), 32'(c == 4'd0));
    chk({tag, "_overflow"}, idx, 32'(overflow), 32'(ov));
  endtask

  task automatic step(input logic w, input logic [7:0] d, input logic [3:0] r);
    wen = w; din = d; ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: stream with all ready
    add(1, 87, 4'b1111, 4'b0000, 0,  1, 0, 0, 0);
    add(1, 56, 4'b1111, 4'b0001, 87, 1, 0, 0, 0);
    add(1, 9,  4'b1111, 4'b0010, 56, 1, 0, 0, 0);
    add(1, 13, 4'b1111, 4'b0100, 9,  1, 0, 0, 0);
    add(0, 0,  4'b1111, 4'b1000, 13, 0, 0, 1, 0);
    add(0, 0,  4'b1111, 4'b0000, 0,  0, 0, 1, 0);
    // 2: fill, overflow, drain
    for (int k = 1; k <= 8; k++) add(1, 8'(k), 4'b0000, 4'b0000, 0, 4'(k), k == 8, 0, 0);
    add(1, 9, 4'b0000, 4'b0000, 0, 8, 1, 0, 1);
    add(0, 0, 4'b0000, 4'b0000, 0, 8, 1, 0, 0);
    for (int k = 1; k <= 8; k++)
      add(0, 0, 4'b1111, 4'(4'b0001 << ((k - 1) % 4)), 8'(k), 4'(8 - k), 0, k == 8, 0);
    add(0, 0, 4'b1111, 4'b0000, 0, 0, 0, 1, 0);
    // 3: skip non-ready channels
    add(1, 85,  4'b0000, 4'b0000, 0, 1, 0, 0, 0);
    add(1, 139, 4'b0000, 4'b0000, 0, 2, 0, 0, 0);
    add(1, 51,  4'b0000, 4'b0000, 0, 3, 0, 0, 0);
    add(1, 7,   4'b0000, 4'b0000, 0, 4, 0, 0, 0);
    add(0, 0, 4'b0101, 4'b0001, 85,  3, 0, 0, 0);
    add(0, 0, 4'b0101, 4'b0100, 139, 2, 0, 0, 0);
    add(0, 0, 4'b0101, 4'b0001, 51,  1, 0, 0, 0);
    add(0, 0, 4'b0101, 4'b0100, 7,   0, 0, 1, 0);
    // 4: wrap from d to a, hold while idle
    add(1, 200, 4'b0000, 4'b0000, 0,   1, 0, 0, 0);
    add(0, 0,   4'b1000, 4'b1000, 200, 0, 0, 1, 0);
    add(1, 11,  4'b0000, 4'b0000, 0,   1, 0, 0, 0);
    add(1, 22,  4'b0000, 4'b0000, 0,   2, 0, 0, 0);
    for (int k = 0; k < 3; k++) add(0, 0, 4'b0000, 4'b0000, 0, 2, 0, 0, 0);
    add(0, 0, 4'b0011, 4'b0001, 11, 1, 0, 0, 0);
    add(0, 0, 4'b0011, 4'b0010, 22, 0, 0, 1, 0);
    // 5: simultaneous push and pop
    add(1, 31, 4'b0000, 4'b0000, 0, 1, 0, 0, 0);
    add(1, 32, 4'b0000, 4'b0000, 0, 2, 0, 0, 0);
    add(1, 33, 4'b0000, 4'b0000, 0, 3, 0, 0, 0);
    for (int k = 0; k < 5; k++) add(1, 8'(34 + k), 4'b0001, 4'b0001, 8'(31 + k), 3, 0, 0, 0);
    for (int k = 0; k < 3; k++) add(0, 0, 4'b0001, 4'b0001, 8'(36 + k), 4'(2 - k), 0, k == 2, 0);
    add(0, 0, 4'b0001, 4'b0000, 0, 0, 0, 1, 0);

    wen = 0; din = 0; ready = 0; rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 4'b0000, 0, 0, 0);
    @(negedge clk);
    rst_n = 1;

    foreach (vecs[i]) begin
      step(vecs[i].wen, vecs[i].din, vecs[i].ready);
      chk_all("vec", i, vecs[i].valid, vecs[i].dout, vecs[i].count, vecs[i].overflow);
      chk("vec_full_tbl", i, 32'(full), 32'(vecs[i].full));
      chk("vec_empty_tbl", i, 32'(empty), 32'(vecs[i].empty));
    end

    // A pop in the same cycle as a write to a full FIFO does not make room.
    for (int k = 0; k < 8; k++) step(1, 8'(100 + k), 4'b0000);
    step(1, 8'hEE, 4'b0001);
    chk_all("fullpop", 0, 4'b0001, 100, 7, 1);
    for (int k = 1; k < 8; k++) begin
      step(0, 0, 4'b0001);
      chk_all("fullpop_drain", k, 4'b0001, 8'(100 + k), 4'(7 - k), 0);
    end
    step(0, 0, 4'b0001);
    chk_all("fullpop_end", 0, 4'b0000, 0, 0, 0);

    // 6: asynchronous reset mid-stream
    for (int k = 0; k < 6; k++) step(1, 8'(60 + k), 4'b0000);
    step(0, 0, 4'b0001);
    chk_all("prereset", 0, 4'b0001, 60, 5, 0);
    #3 rst_n = 0;
    #1 chk_all("async_reset", 0, 4'b0000, 0, 0, 0);
    @(negedge clk);
    rst_n = 1;
    step(1, 51, 4'b1111);
    chk_all("post_reset_wr", 0, 4'b0000, 0, 1, 0);
    step(0, 0, 4'b1111);
    chk_all("post_reset_rd", 0, 4'b0001, 51, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/round_robin_fifo_dispatcher.md
Name: round_robin_fifo_dispatcher

Overview:
Single-producer, four-consumer dispatcher. It buffers one 8-bit input stream in an internal FIFO and hands each word to exactly one of four consumer channels (a, b, c, d) in round-robin order. Only channels that assert ready are served. It is the write-side counterpart of the four-FIFO round-robin arbiter: that block merges four streams into one, and this block splits one stream into four.

Parameters:
WIDTH, 8, data word width
DEPTH, 8, FIFO depth in words; must be a power of two and at least 2
CW, 4, count width; must equal log2(DEPTH)+1

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  reset; asynchronous, active-low
wen  input  1  write request for din
din  input  WIDTH  write data
ready  input  4  consumer ready; bit0=a, bit1=b, bit2=c, bit3=d
dout  output  WIDTH  dispatched word (registered)
valid  output  4  one-hot channel select for dout; 0000 means no transfer (registered)
full  output  1  FIFO holds DEPTH words
empty  output  1  FIFO holds 0 words
count  output  CW  current occupancy, 0..DEPTH
overflow  output  1  one-cycle pulse when a write is rejected

Behaviour:
- Reset (rst_n low, asynchronous): rd_ptr=0, wr_ptr=0, count=0, rr_ptr=0 (channel a).
  - Outputs: dout=0, valid=0000, overflow=0, full=0, empty=1.
  - Reset mid-operation discards all stored words.
- full and empty are combinational from count.
- All decisions in a cycle use pre-edge state.
- Write rule:
  - wen=1 and full=0 at an edge: store din at wr_ptr, and wr_ptr advances mod DEPTH.
  - wen=1 and full=1: write dropped and overflow=1 for the next cycle. Otherwise overflow=0.
  - A pop in the same cycle does not free space for that cycle's write.
- Dispatch rule, evaluated every edge:
  - If empty=0 and ready!=0000: select channel i = first set ready bit, searching rr_ptr, rr_ptr+1, ... mod 4.
    - Pop the head: dout<=mem[rd_ptr], valid<=(1<<i), rd_ptr advances mod DEPTH.
    - rr_ptr<=(i+1) mod 4; from 3 it wraps to 0.
  - Otherwise: dout<=0, valid<=0000, rr_ptr unchanged.
- No write-to-read bypass.
  - A word written at edge N is dispatched at edge N+1 at the earliest, so it appears on dout/valid during the cycle after edge N+1.
- Simultaneous push and pop: both occur and count is unchanged.
- count: +1 on push only, -1 on pop only.
- Both pointers wrap mod DEPTH.
- Invariant: valid is always 0000 or one-hot. dout is 0 whenever valid=0000.
- Consumers are not backpressured after selection: a word shown with valid is considered delivered.

Test Plan:
1. Stream with all channels ready.
   - Stimulus: after reset, ready=1111; wen=1 with din=87, 56, 9, 13 on consecutive cycles.
   - Required: valid=0001/87, 0010/56, 0100/9, 1000/13 on consecutive cycles, starting one cycle after the first write; then valid=0000, dout=0, empty=1.
2. Fill and overflow.
   - Stimulus: ready=0000; write 9 words, 1 through 9.
   - Required: count=8 and full=1 after the 8th write; the 9th write is dropped and overflow=1 for exactly one cycle.
   - Follow-up: set ready=1111. Required: words 1 through 8 come out on channels a, b, c, d, a, b, c, d; word 9 never appears.
3. Skipping non-ready channels.
   - Stimulus: ready=0101 with 4 words queued (85, 139, 51, 7).
   - Required: valid=0001/85, 0100/139, 0001/51, 0100/7.
4. Round-robin wrap and hold.
   - Stimulus: ready=1000 and dispatch one word; then set ready=0011 with two words queued.
   - Required: the first dispatch goes to channel a (rr_ptr wrapped to 0), the next to channel b.
   - Also: with ready=0000 for several cycles, rr_ptr holds its value.
5. Simultaneous push and pop.
   - Stimulus: count=3, ready=0001, wen=1 every cycle for 5 cycles.
   - Required: count stays 3 and the words come out in FIFO order on channel a.
6. Asynchronous reset mid-stream.
   - Stimulus: count=5, rst_n driven low between clock edges.
   - Required: valid=0000, dout=0, count=0, empty=1 immediately. After release, a new write of 51 is dispatched to channel a.
